// File: rtl/data_memory_pkg.sv
// Shared CPU datapath constants and types.
// Word width, address width, default data RAM depth, clog2 helper.
package data_memory_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int DEPTH_DEF = 256;

  typedef logic [DATA_W-1:0] word_t;

  // Index width for tools without $clog2; never below 1.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/data_memory.sv
// Word-addressed data RAM, register array, async active-low clear.
// Ports: WD, Clock, Adresa, MemWrite, MemRead, ReadData, Reset_n.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic [DATA_W-1:0] WD,
  input  logic              Clock,
  input  logic [ADDR_W-1:0] Adresa,
  input  logic              MemWrite,
  input  logic              MemRead,
  output logic [DATA_W-1:0] ReadData,
  input  logic              Reset_n
);

  localparam int IDX_W = clog2(DEPTH);

  word_t            mem [DEPTH];
  logic [IDX_W-1:0] idx;

  // Upper address bits alias modulo DEPTH.
  assign idx = Adresa[IDX_W-1:0];

  generate
    if (IDX_W < ADDR_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^Adresa[ADDR_W-1:IDX_W];
    end
  endgenerate

  // An X/Z enable fails the if test, so it acts as no write.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (MemWrite) begin
      mem[idx] <= WD;
    end
  end

  assign ReadData = MemRead ? mem[idx] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
// Hand-computed vectors; one summary line at the end.
module tb_data_memory;

  logic [15:0] WD;
  logic        Clock;
  logic [15:0] Adresa;
  logic        MemWrite;
  logic        MemRead;
  logic [15:0] ReadData;
  logic        Reset_n;

  int n_cmp;
  int n_bad;

  data_memory dut (
    .WD       (WD),
    .Clock    (Clock),
    .Adresa   (Adresa),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .ReadData (ReadData),
    .Reset_n  (Reset_n)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a,
                    input logic [15:0] d);
    @(negedge Clock);
    MemWrite = 1'b1;
    MemRead  = 1'b0;
    Adresa   = a;
    WD       = d;
    @(posedge Clock);
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [15:0] a,
                    input logic [15:0] exp);
    MemRead = 1'b1;
    Adresa  = a;
    #1;
    chk(tag, ReadData, exp);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    Reset_n  = 1'b0;
    MemWrite = 1'b0;
    MemRead  = 1'b1;
    Adresa   = 16'd0;
    WD       = 16'h0;
    #12;
    chk("rst_rd0", ReadData, 16'h0000);
    Adresa = 16'd255;
    #1;
    chk("rst_rd255", ReadData, 16'h0000);
    @(negedge Clock);
    Reset_n = 1'b1;

    // First edge after release may write.
    wr(16'd8, 16'h8888);
    rd("first_wr", 16'd8, 16'h8888);

    wr(16'd10, 16'h1234);
    rd("wr_rd10", 16'd10, 16'h1234);
    MemRead = 1'b0;
    #1;
    chk("rd_gate", ReadData, 16'h0000);

    // Asynchronous clear, mid-cycle.
    wr(16'd5, 16'hBEEF);
    rd("pre_clr5", 16'd5, 16'hBEEF);
    @(negedge Clock);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("clr5", ReadData, 16'h0000);
    Reset_n = 1'b1;
    rd("clr10", 16'd10, 16'h0000);
    rd("clr8", 16'd8, 16'h0000);

    // Address wrap.
    wr(16'd266, 16'hA5A5);
    rd("wrap10", 16'd10, 16'hA5A5);
    rd("wrap266", 16'd266, 16'hA5A5);
    wr(16'hFFFF, 16'h5A5A);
    rd("wrap255", 16'd255, 16'h5A5A);
    rd("wrap0", 16'd0, 16'h0000);

    // Read and write together, same index.
    wr(16'd20, 16'h0001);
    @(negedge Clock);
    MemRead  = 1'b1;
    MemWrite = 1'b1;
    Adresa   = 16'd20;
    WD       = 16'h00FF;
    #1;
    chk("rw_before", ReadData, 16'h0001);
    @(posedge Clock);
    #1;
    chk("rw_after", ReadData, 16'h00FF);
    MemWrite = 1'b0;

    // Isolation and hold.
    wr(16'd3, 16'h1111);
    wr(16'd4, 16'h2222);
    WD = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      Adresa = 16'(i + 3);
    end
    @(posedge Clock);
    #1;
    rd("hold3", 16'd3, 16'h1111);
    rd("hold4", 16'd4, 16'h2222);
    rd("hold20", 16'd20, 16'h00FF);
    rd("hold10", 16'd10, 16'hA5A5);

    // X enable means no write.
    wr(16'd9, 16'h9999);
    @(negedge Clock);
    MemWrite = 1'bx;
    Adresa   = 16'd9;
    WD       = 16'h0000;
    @(posedge Clock);
    #1;
    MemWrite = 1'b0;
    rd("x_we", 16'd9, 16'h9999);

    // Reset beats a write at the same edge.
    @(negedge Clock);
    Reset_n  = 1'b0;
    MemWrite = 1'b1;
    Adresa   = 16'd7;
    WD       = 16'h7777;
    @(posedge Clock);
    #1;
    @(negedge Clock);
    MemWrite = 1'b0;
    Reset_n  = 1'b1;
    rd("rst_wins7", 16'd7, 16'h0000);
    rd("rst_clr9", 16'd9, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
